// File: rtl/jzjpcc_memory_arbiter.sv
// Arbitrates one synchronous-read RAM port between instruction fetch and data access.
// Define JZJPCC_MEMORY_ARBITER_ANTISTARVE_EN to bound how long fetch can be held off by data.
module jzjpcc_memory_arbiter #(
    parameter int RAM_A_WIDTH  = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   fetchReq,
    input  logic [RAM_A_WIDTH-1:0] fetchAddr,
    output logic                   fetchStall,
    output logic [31:0]            fetchData,
    output logic                   fetchDataValid,
    input  logic                   dataReq,
    input  logic                   dataWrite,
    input  logic [RAM_A_WIDTH-1:0] dataAddr,
    input  logic [31:0]            dataWriteData,
    input  logic [3:0]             dataByteMask,
    output logic                   dataStall,
    output logic [31:0]            dataReadData,
    output logic                   dataReadValid,
    output logic [RAM_A_WIDTH-1:0] ramAddr,
    output logic                   ramWriteEnable,
    output logic [3:0]             ramByteMask,
    output logic [31:0]            ramWriteData,
    input  logic [31:0]            ramReadData,
    output logic [1:0]             dbgOwner
);

    // Handshake: a request is accepted in a cycle where req=1 and stall=0; requesters
    // hold req and operands stable while stalled. Read data is valid exactly one cycle later.

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

    owner_e owner_q, owner_d;
    logic   grant_fetch;
    logic   grant_data;
    logic   force_fetch;

    if (STARVE_LIMIT < 1) begin : g_starve_limit_invalid
    end

`ifdef JZJPCC_MEMORY_ARBITER_ANTISTARVE_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_q, starve_d;

    assign force_fetch = (starve_q == LIMIT);

    // Counts consecutive cycles in which data won while fetch was waiting.
    always_comb begin
        starve_d = starve_q;
        if (!fetchReq || grant_fetch) begin
            starve_d = '0;
        end else if (grant_data && (starve_q != LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_fetch = 1'b0;
`endif

    always_comb begin
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        if (!reset) begin
            if (fetchReq && dataReq) begin
                grant_fetch = force_fetch;
                grant_data  = !force_fetch;
            end else begin
                grant_fetch = fetchReq;
                grant_data  = dataReq;
            end
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (grant_fetch) begin
            owner_d = OWN_FETCH;
        end else if (grant_data && !dataWrite) begin
            owner_d = OWN_DATA;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign fetchStall     = fetchReq && !grant_fetch;
    assign dataStall      = dataReq && !grant_data;
    assign ramAddr        = grant_data ? dataAddr : fetchAddr;
    assign ramWriteEnable = grant_data && dataWrite;
    assign ramByteMask    = ramWriteEnable ? dataByteMask : 4'b0000;
    assign ramWriteData   = dataWriteData;

    // Gating by reset drops the return of a read that was in flight when reset arrived.
    assign fetchDataValid = (owner_q == OWN_FETCH) && !reset;
    assign dataReadValid  = (owner_q == OWN_DATA) && !reset;
    assign fetchData      = ramReadData;
    assign dataReadData   = ramReadData;
    assign dbgOwner       = owner_q;

endmodule

// File: tb/tb_jzjpcc_memory_arbiter.sv
// Bench for jzjpcc_memory_arbiter: directed vector table, starvation sequence, random traffic.
// Works with or without JZJPCC_MEMORY_ARBITER_ANTISTARVE_EN defined.
module tb_jzjpcc_memory_arbiter;

    localparam int AW    = 12;
    localparam int LIMIT = 4;
`ifdef JZJPCC_MEMORY_ARBITER_ANTISTARVE_EN
    localparam bit ANTI = 1'b1;
`else
    localparam bit ANTI = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          fetchReq;
    logic [AW-1:0] fetchAddr;
    logic          fetchStall;
    logic [31:0]   fetchData;
    logic          fetchDataValid;
    logic          dataReq;
    logic          dataWrite;
    logic [AW-1:0] dataAddr;
    logic [31:0]   dataWriteData;
    logic [3:0]    dataByteMask;
    logic          dataStall;
    logic [31:0]   dataReadData;
    logic          dataReadValid;
    logic [AW-1:0] ramAddr;
    logic          ramWriteEnable;
    logic [3:0]    ramByteMask;
    logic [31:0]   ramWriteData;
    logic [31:0]   ramReadData;
    logic [1:0]    dbgOwner;

    int checks   = 0;
    int failures = 0;

    jzjpcc_memory_arbiter #(.RAM_A_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .fetchReq(fetchReq), .fetchAddr(fetchAddr), .fetchStall(fetchStall),
        .fetchData(fetchData), .fetchDataValid(fetchDataValid),
        .dataReq(dataReq), .dataWrite(dataWrite), .dataAddr(dataAddr),
        .dataWriteData(dataWriteData), .dataByteMask(dataByteMask),
        .dataStall(dataStall), .dataReadData(dataReadData), .dataReadValid(dataReadValid),
        .ramAddr(ramAddr), .ramWriteEnable(ramWriteEnable), .ramByteMask(ramByteMask),
        .ramWriteData(ramWriteData), .ramReadData(ramReadData), .dbgOwner(dbgOwner)
    );

    // Clock
    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(input logic [AW-1:0] a);
        if (a == 12'h010) return 32'h00500093;
        return 32'hA5A50000 | {20'h0, a};
    endfunction

    // RAM environment: synchronous read, byte-masked write
    bit [31:0] ram_mem [0:4095];
    bit        ram_written [0:4095];
    always @(posedge clock) begin
        logic [31:0] cur;
        cur = ram_written[ramAddr] ? ram_mem[ramAddr] : init_word(ramAddr);
        ramReadData <= cur;
        if (ramWriteEnable) begin
            for (int b = 0; b < 4; b++)
                if (ramByteMask[b]) cur[8*b +: 8] = ramWriteData[8*b +: 8];
            ram_mem[ramAddr]     <= cur;
            ram_written[ramAddr] <= 1'b1;
        end
    end

    // Reference model: rules of the arbiter expressed directly
    logic [31:0] m_mem [int];
    bit          m_pend_f, m_pend_d;
    logic [31:0] m_pend_data;
    int          m_wait;        // consecutive cycles fetch has lost to data
    bit          m_gf, m_gd, m_fs, m_ds;

    function automatic logic [31:0] m_read(input logic [AW-1:0] a);
        if (m_mem.exists(int'(a))) return m_mem[int'(a)];
        return init_word(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_decide();
        m_gf = 1'b0;
        m_gd = 1'b0;
        if (!reset) begin
            if (fetchReq && dataReq) begin
                if (ANTI && m_wait >= LIMIT) m_gf = 1'b1;
                else m_gd = 1'b1;
            end else begin
                m_gf = fetchReq;
                m_gd = dataReq;
            end
        end
        m_fs = fetchReq && !m_gf;
        m_ds = dataReq && !m_gd;
    endtask

    // Sample on the falling edge and compare everything against the model.
    task automatic check_cycle();
        logic        e_we;
        logic [31:0] e_addr;
        model_decide();
        @(negedge clock);
        e_we   = m_gd && dataWrite;
        e_addr = {20'h0, (m_gd ? dataAddr : fetchAddr)};
        chk("fetchStall", {31'h0, fetchStall}, {31'h0, m_fs});
        chk("dataStall", {31'h0, dataStall}, {31'h0, m_ds});
        chk("ramWriteEnable", {31'h0, ramWriteEnable}, {31'h0, e_we});
        chk("ramByteMask", {28'h0, ramByteMask}, {28'h0, (e_we ? dataByteMask : 4'h0)});
        chk("ramAddr", {20'h0, ramAddr}, e_addr);
        chk("ramWriteData", ramWriteData, dataWriteData);
        chk("fetchDataValid", {31'h0, fetchDataValid}, {31'h0, (m_pend_f && !reset)});
        chk("dataReadValid", {31'h0, dataReadValid}, {31'h0, (m_pend_d && !reset)});
        if (m_pend_f && !reset) chk("fetchData", fetchData, m_pend_data);
        if (m_pend_d && !reset) chk("dataReadData", dataReadData, m_pend_data);
    endtask

    task automatic advance();
        @(posedge clock);
        if (reset) begin
            m_pend_f = 1'b0;
            m_pend_d = 1'b0;
            m_wait   = 0;
        end else begin
            m_pend_f    = m_gf;
            m_pend_d    = m_gd && !dataWrite;
            m_pend_data = m_read(m_gd ? dataAddr : fetchAddr);
            if (m_gd && dataWrite) begin
                logic [31:0] w;
                w = m_read(dataAddr);
                for (int b = 0; b < 4; b++)
                    if (dataByteMask[b]) w[8*b +: 8] = dataWriteData[8*b +: 8];
                m_mem[int'(dataAddr)] = w;
            end
            if (fetchReq && !m_gf) m_wait = m_wait + 1;
            else m_wait = 0;
        end
        #1;
    endtask

    task automatic drive(input logic rst, input logic fr, input logic [AW-1:0] fa,
                         input logic dr, input logic dw, input logic [AW-1:0] da,
                         input logic [31:0] wd, input logic [3:0] bm);
        reset = rst; fetchReq = fr; fetchAddr = fa;
        dataReq = dr; dataWrite = dw; dataAddr = da; dataWriteData = wd; dataByteMask = bm;
    endtask

    typedef struct {
        logic          rst, fr;
        logic [AW-1:0] fa;
        logic          dr, dw;
        logic [AW-1:0] da;
        logic [31:0]   wd;
        logic [3:0]    bm;
        logic          e_fs, e_ds, e_we;
        logic [3:0]    e_bm;
        logic          e_fv, e_dv;
        logic [31:0]   e_rd;
    } vec_t;

    vec_t vecs [18];

    initial begin
        // Directed vectors (expected outputs apply to the cycle in which the row's inputs are held)
        vecs[0]  = '{1, 1, 12'h010, 1, 1, 12'h020, 32'h11111111, 4'hF, 1, 1, 0, 4'h0, 0, 0, 32'h0};
        vecs[1]  = '{0, 1, 12'h010, 0, 0, 12'h000, 32'h0,        4'h0, 0, 0, 0, 4'h0, 0, 0, 32'h0};
        vecs[2]  = '{0, 0, 12'h000, 0, 0, 12'h000, 32'h0,        4'h0, 0, 0, 0, 4'h0, 1, 0, 32'h00500093};
        vecs[3]  = '{0, 0, 12'h000, 1, 1, 12'h020, 32'hDEADBEEF, 4'h3, 0, 0, 1, 4'h3, 0, 0, 32'h0};
        vecs[4]  = '{0, 0, 12'h000, 1, 0, 12'h020, 32'h0,        4'h0, 0, 0, 0, 4'h0, 0, 0, 32'h0};
        vecs[5]  = '{0, 0, 12'h000, 0, 0, 12'h000, 32'h0,        4'h0, 0, 0, 0, 4'h0, 0, 1, 32'hA5A5BEEF};
        vecs[6]  = '{0, 1, 12'h040, 1, 0, 12'h030, 32'h0,        4'h0, 1, 0, 0, 4'h0, 0, 0, 32'h0};
        vecs[7]  = '{0, 1, 12'h040, 0, 0, 12'h000, 32'h0,        4'h0, 0, 0, 0, 4'h0, 0, 1, 32'hA5A50030};
        vecs[8]  = '{0, 0, 12'h000, 0, 0, 12'h000, 32'h0,        4'h0, 0, 0, 0, 4'h0, 1, 0, 32'hA5A50040};
        vecs[9]  = '{0, 1, 12'h060, 1, 1, 12'h070, 32'h12345678, 4'hF, 1, 0, 1, 4'hF, 0, 0, 32'h0};
        vecs[10] = '{0, 1, 12'h060, 0, 0, 12'h000, 32'h0,        4'h0, 0, 0, 0, 4'h0, 0, 0, 32'h0};
        vecs[11] = '{0, 0, 12'h000, 0, 0, 12'h000, 32'h0,        4'h0, 0, 0, 0, 4'h0, 1, 0, 32'hA5A50060};
        vecs[12] = '{0, 0, 12'h000, 1, 0, 12'h050, 32'h0,        4'h0, 0, 0, 0, 4'h0, 0, 0, 32'h0};
        vecs[13] = '{1, 1, 12'h080, 1, 0, 12'h050, 32'h0,        4'h0, 1, 1, 0, 4'h0, 0, 0, 32'h0};
        vecs[14] = '{0, 1, 12'h080, 0, 0, 12'h000, 32'h0,        4'h0, 0, 0, 0, 4'h0, 0, 0, 32'h0};
        vecs[15] = '{0, 0, 12'h000, 1, 0, 12'h070, 32'h0,        4'h0, 0, 0, 0, 4'h0, 1, 0, 32'hA5A50080};
        vecs[16] = '{0, 0, 12'h000, 0, 0, 12'h000, 32'h0,        4'h0, 0, 0, 0, 4'h0, 0, 1, 32'h12345678};
        vecs[17] = '{0, 0, 12'h000, 0, 0, 12'h000, 32'h0,        4'h0, 0, 0, 0, 4'h0, 0, 0, 32'h0};

        m_pend_f = 1'b0; m_pend_d = 1'b0; m_wait = 0; m_pend_data = '0;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            check_cycle();
            advance();
        end

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].rst, vecs[i].fr, vecs[i].fa, vecs[i].dr, vecs[i].dw,
                  vecs[i].da, vecs[i].wd, vecs[i].bm);
            check_cycle();
            chk($sformatf("vec%0d.fetchStall", i), {31'h0, fetchStall}, {31'h0, vecs[i].e_fs});
            chk($sformatf("vec%0d.dataStall", i), {31'h0, dataStall}, {31'h0, vecs[i].e_ds});
            chk($sformatf("vec%0d.ramWriteEnable", i), {31'h0, ramWriteEnable}, {31'h0, vecs[i].e_we});
            chk($sformatf("vec%0d.ramByteMask", i), {28'h0, ramByteMask}, {28'h0, vecs[i].e_bm});
            chk($sformatf("vec%0d.fetchDataValid", i), {31'h0, fetchDataValid}, {31'h0, vecs[i].e_fv});
            chk($sformatf("vec%0d.dataReadValid", i), {31'h0, dataReadValid}, {31'h0, vecs[i].e_dv});
            if (vecs[i].e_fv) chk($sformatf("vec%0d.fetchData", i), fetchData, vecs[i].e_rd);
            if (vecs[i].e_dv) chk($sformatf("vec%0d.dataReadData", i), dataReadData, vecs[i].e_rd);
            advance();
        end

        // Both requesters held for six cycles: fetch forced through only with anti-starvation.
        for (int i = 0; i < 6; i++) begin
            logic e_fs;
            drive(0, 1, 12'h100, 1, 0, AW'(12'h200 + i), 32'h0, 4'h0);
            e_fs = ANTI ? (i != 4) : 1'b1;
            check_cycle();
            chk($sformatf("starve%0d.fetchStall", i), {31'h0, fetchStall}, {31'h0, e_fs});
            chk($sformatf("starve%0d.dataStall", i), {31'h0, dataStall}, {31'h0, !e_fs});
            advance();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            check_cycle();
            advance();
        end

        // Random traffic; stalled requesters keep their operands.
        for (int i = 0; i < 500; i++) begin
            logic hold_f, hold_d;
            hold_f = m_fs;
            hold_d = m_ds;
            reset = ($urandom_range(0, 39) == 0);
            if (!hold_f) begin
                fetchReq  = ($urandom_range(0, 9) < 7);
                fetchAddr = AW'($urandom_range(0, 31));
            end
            if (!hold_d) begin
                dataReq       = ($urandom_range(0, 9) < 7);
                dataWrite     = ($urandom_range(0, 2) == 0);
                dataAddr      = AW'($urandom_range(0, 31));
                dataWriteData = $urandom;
                dataByteMask  = 4'($urandom_range(0, 15));
            end
            check_cycle();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
